// File: rtl/mem_bridge_pkg.sv
// Shared types for the core-to-memory bridge: FSM encodings and the
// posted-write buffer entry layout.
package mem_bridge_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_BRAM_RD = 3'd1;
    localparam state_t ST_DRAIN   = 3'd2;
    localparam state_t ST_DDR_RD  = 3'd3;
    localparam state_t ST_RESP    = 3'd4;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Small synchronous FIFO holding posted DDR2 writes; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module wbuf_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Routes core load/store requests to BRAM or DDR2, posting DDR2 writes into a
// buffer and returning exactly one response per read.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int                      DATA_W     = PKG_DATA_W,
    parameter int                      ADDR_W     = PKG_ADDR_W,
    parameter logic [ADDR_W-1:0]       DDR_BASE   = 32'h0010_0000,
    parameter int                      BRAM_LAT   = 1,
    parameter int                      WBUF_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [DATA_W-1:0]               req_wd,
    output logic                            resp_valid,
    output logic [DATA_W-1:0]               resp_rd,
    output logic                            bram_en,
    output logic                            bram_we,
    output logic [ADDR_W-1:0]               bram_addr,
    output logic [DATA_W-1:0]               bram_wd,
    input  logic [DATA_W-1:0]               bram_rd,
    input  logic                            ddr2_stall,
    input  logic [DATA_W-1:0]               ddr2_rd,
    output logic                            ddr2_en,
    output logic                            ddr2_we,
    output logic [ADDR_W-1:0]               ddr2_addr,
    output logic [DATA_W-1:0]               ddr2_wd,
    output logic [$clog2(WBUF_DEPTH+1)-1:0] wbuf_count
);

    state_t            state;
    state_t            state_next;
    logic [2:0]        lat_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic              is_ddr;
    logic              accept;
    logic              push;
    logic              pop;
    logic              bram_read_go;
    logic              ddr_read_go;
    logic              ddr_done;
    logic              read_done;
    logic              bram_sample;
    logic              wb_full;
    logic              wb_empty;
    wbuf_entry_t       push_entry;
    wbuf_entry_t       head_entry;

    assign is_ddr       = (req_addr >= DDR_BASE);
    assign req_ready    = ((state == ST_IDLE) || (state == ST_RESP)) && !(req_we && is_ddr && wb_full);
    assign accept       = req_valid && req_ready;
    assign push         = accept && req_we && is_ddr;
    assign bram_read_go = accept && !req_we && !is_ddr;
    assign ddr_read_go  = accept && !req_we && is_ddr;

    assign push_entry.addr = req_addr;
    assign push_entry.data = req_wd;

    wbuf_fifo #(
        .WIDTH ($bits(wbuf_entry_t)),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (wb_full),
        .empty (wb_empty),
        .count (wbuf_count)
    );

    // BRAM is driven straight from the request so it never waits on DDR2 traffic.
    assign bram_en   = accept && !is_ddr;
    assign bram_we   = bram_en && req_we;
    assign bram_addr = bram_en ? req_addr : '0;
    assign bram_wd   = bram_en ? req_wd : '0;

    // The buffer head always wins the DDR2 port, which keeps posted writes ahead of reads.
    always_comb begin
        ddr2_en   = 1'b0;
        ddr2_we   = 1'b0;
        ddr2_addr = '0;
        ddr2_wd   = '0;
        if (!wb_empty) begin
            ddr2_en   = 1'b1;
            ddr2_we   = 1'b1;
            ddr2_addr = head_entry.addr - DDR_BASE;
            ddr2_wd   = head_entry.data;
        end else if (state == ST_DDR_RD) begin
            ddr2_en   = 1'b1;
            ddr2_addr = rd_addr;
        end
    end

    assign ddr_done    = ddr2_en && !ddr2_stall;
    assign pop         = ddr_done && !wb_empty;
    assign read_done   = ddr_done && wb_empty && (state == ST_DDR_RD);
    assign bram_sample = (state == ST_BRAM_RD) && (lat_cnt == 3'(BRAM_LAT));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                state_next = ST_IDLE;
                if (bram_read_go) begin
                    state_next = ST_BRAM_RD;
                end else if (ddr_read_go) begin
                    state_next = (wbuf_count != '0) ? ST_DRAIN : ST_DDR_RD;
                end
            end
            ST_BRAM_RD: if (bram_sample) state_next = ST_RESP;
            ST_DRAIN:   if (wb_empty)    state_next = ST_DDR_RD;
            ST_DDR_RD:  if (read_done)   state_next = ST_RESP;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            state <= state_next;
            if (bram_read_go) begin
                lat_cnt <= 3'd1;
            end else if (state == ST_BRAM_RD) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
            if (ddr_read_go) begin
                rd_addr <= req_addr - DDR_BASE;
            end
            if (bram_sample) begin
                rd_data <= bram_rd;
            end else if (read_done) begin
                rd_data <= ddr2_rd;
            end
        end
    end

    assign resp_valid = (state == ST_RESP);
    assign resp_rd    = rd_data;

endmodule
